// File: rtl/ensemble_pkg.sv
// Shared types and decision-word layout for the ensemble vote combiner.
// Bit offsets are relative to CLASS_WIDTH, the end of the class field.
package ensemble_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        TALLY   = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    localparam int CNT_OFS  = 0;
    localparam int CNT_BITS = 8;
    localparam int TIE_OFS  = 8;
    localparam int UNAN_OFS = 9;
    localparam int REJ_OFS  = 10;

    localparam logic [15:0] NO_DECISION = 16'hFFFF;

endpackage

// File: rtl/vote_slot.sv
// Single-entry capture register for one classifier channel.
// Stores the class field and tlast of one beat per sample.
module vote_slot #(
    parameter int DATA_WIDTH  = 32,
    parameter int CLASS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   collect,
    input  logic                   clear,
    input  logic [DATA_WIDTH-1:0]  tdata,
    input  logic                   tvalid,
    input  logic                   tlast,
    output logic                   tready,
    output logic [CLASS_WIDTH-1:0] cls,
    output logic                   last,
    output logic                   full
);

    logic [CLASS_WIDTH-1:0] cls_r;
    logic                   last_r;
    logic                   full_r;
    logic                   capture_s;
    logic                   data_unused_s;

    // Only the class field takes part in the vote.
    assign data_unused_s = ^tdata[DATA_WIDTH-1:CLASS_WIDTH];

    // Disabled channels are drained so upstream never stalls on them.
    assign tready    = ~rst & collect & (~en | ~full_r);
    assign capture_s = collect & en & ~full_r & tvalid;

    assign cls  = cls_r;
    assign last = last_r;
    assign full = full_r;

    // Capture register and full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_r  <= {CLASS_WIDTH{1'b0}};
            last_r <= 1'b0;
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (capture_s) begin
            cls_r  <= tdata[CLASS_WIDTH-1:0];
            last_r <= tlast;
            full_r <= 1'b1;
        end
    end

endmodule

// File: rtl/ensemble_vote_combiner.sv
// Aligns one result beat per classifier, tallies a plurality vote over
// all legal classes and emits one thresholded decision word per sample.
module ensemble_vote_combiner
    import ensemble_pkg::*;
#(
    parameter int NUM_CLF     = 3,
    parameter int NUM_CLASSES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLF*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CLF*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_CLF-1:0]            s_axis_tvalid,
    output logic [NUM_CLF-1:0]            s_axis_tready,
    input  logic [NUM_CLF-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic [NUM_CLF-1:0]            clf_en,
    input  logic [$clog2(NUM_CLF+1)-1:0]  min_votes,
    output logic                          tlast_err
);

    localparam int CW = $clog2(NUM_CLF + 1);

    state_t                 state_r, state_s;
    logic [NUM_CLF-1:0]     en_r, en_eff_s, full_s, last_s;
    logic [CLASS_WIDTH-1:0] slot_cls_s [NUM_CLF];
    logic [CW-1:0]          thr_r, best_cnt_r, cnt_s, nb_cnt_s, en_cnt_s;
    logic [CLASS_WIDTH-1:0] cls_r, best_cls_r, nb_cls_s;
    logic                   tie_r, nb_tie_s, tlast_r, tlast_err_r, reject_s;
    logic                   all_done_s, tally_end_s, handshake_s, collect_s;
    logic                   all_last_s, any_last_s, keep_unused_s;
    logic [DATA_WIDTH-1:0]  tdata_r, word_s;

    assign keep_unused_s = ^s_axis_tkeep;
    assign collect_s     = (state_r == COLLECT);
    assign handshake_s   = (state_r == OUTPUT) && m_axis_tready;
    // While every slot is empty the live mask applies, so the first beat of a sample is never dropped.
    assign en_eff_s      = (|full_s) ? en_r : clf_en;
    assign all_done_s    = (en_r != {NUM_CLF{1'b0}}) && ((full_s & en_r) == en_r);
    assign tally_end_s   = (state_r == TALLY) && (cls_r == CLASS_WIDTH'(NUM_CLASSES - 1));
    assign all_last_s    = &(last_s | ~en_r);
    assign any_last_s    = |(last_s & en_r);

    genvar g;
    generate
        for (g = 0; g < NUM_CLF; g++) begin : g_slot
            vote_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .CLASS_WIDTH(CLASS_WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .en    (en_eff_s[g]),
                .collect(collect_s),
                .clear (handshake_s),
                .tdata (s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
                .tvalid(s_axis_tvalid[g]),
                .tlast (s_axis_tlast[g]),
                .tready(s_axis_tready[g]),
                .cls   (slot_cls_s[g]),
                .last  (last_s[g]),
                .full  (full_s[g])
            );
        end
    endgenerate

    // Votes for the class under test and size of the enabled set.
    always_comb begin
        cnt_s    = {CW{1'b0}};
        en_cnt_s = {CW{1'b0}};
        for (int i = 0; i < NUM_CLF; i++) begin
            if (en_r[i] && full_s[i] && (slot_cls_s[i] == cls_r)) begin
                cnt_s = cnt_s + CW'(1);
            end else begin
                cnt_s = cnt_s;
            end
            if (en_r[i]) begin
                en_cnt_s = en_cnt_s + CW'(1);
            end else begin
                en_cnt_s = en_cnt_s;
            end
        end
    end

    // Best tracker update; strict compare keeps ties on the lowest class.
    always_comb begin
        nb_cnt_s = best_cnt_r;
        nb_cls_s = best_cls_r;
        nb_tie_s = tie_r;
        if (cnt_s > best_cnt_r) begin
            nb_cnt_s = cnt_s;
            nb_cls_s = cls_r;
            nb_tie_s = 1'b0;
        end else if ((cnt_s == best_cnt_r) && (cnt_s != {CW{1'b0}})) begin
            nb_tie_s = 1'b1;
        end else begin
            nb_tie_s = tie_r;
        end
    end

    // Decision word assembled from the final best tracker state.
    always_comb begin
        reject_s = (nb_cnt_s < thr_r) || (nb_cnt_s == {CW{1'b0}});
        word_s   = {DATA_WIDTH{1'b0}};
        word_s[CLASS_WIDTH-1:0] = reject_s ? NO_DECISION[CLASS_WIDTH-1:0] : nb_cls_s;
        word_s[CLASS_WIDTH+CNT_OFS +: CNT_BITS] = CNT_BITS'(nb_cnt_s);
        word_s[CLASS_WIDTH+TIE_OFS]  = nb_tie_s;
        word_s[CLASS_WIDTH+UNAN_OFS] = (nb_cnt_s == en_cnt_s);
        word_s[CLASS_WIDTH+REJ_OFS]  = reject_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            COLLECT: state_s = all_done_s  ? TALLY   : COLLECT;
            TALLY:   state_s = tally_end_s ? OUTPUT  : TALLY;
            OUTPUT:  state_s = m_axis_tready ? COLLECT : OUTPUT;
            default: state_s = COLLECT;
        endcase
    end

    // State, configuration latches, tally counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= COLLECT;
            en_r        <= {NUM_CLF{1'b0}};
            thr_r       <= {CW{1'b0}};
            cls_r       <= {CLASS_WIDTH{1'b0}};
            best_cls_r  <= {CLASS_WIDTH{1'b0}};
            best_cnt_r  <= {CW{1'b0}};
            tie_r       <= 1'b0;
            tdata_r     <= {DATA_WIDTH{1'b0}};
            tlast_r     <= 1'b0;
            tlast_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (!(|full_s)) begin
                en_r  <= clf_en;
                thr_r <= min_votes;
            end
            case (state_r)
                COLLECT: begin
                    if (all_done_s) begin
                        cls_r      <= {CLASS_WIDTH{1'b0}};
                        best_cls_r <= {CLASS_WIDTH{1'b0}};
                        best_cnt_r <= {CW{1'b0}};
                        tie_r      <= 1'b0;
                        if (any_last_s && !all_last_s) begin
                            tlast_err_r <= 1'b1;
                        end
                    end
                end
                TALLY: begin
                    cls_r      <= cls_r + CLASS_WIDTH'(1);
                    best_cls_r <= nb_cls_s;
                    best_cnt_r <= nb_cnt_s;
                    tie_r      <= nb_tie_s;
                    if (tally_end_s) begin
                        tdata_r <= word_s;
                        tlast_r <= all_last_s;
                    end
                end
                OUTPUT: begin
                    if (m_axis_tready) begin
                        tdata_r <= {DATA_WIDTH{1'b0}};
                        tlast_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (state_r == OUTPUT);
    assign m_axis_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign tlast_err     = tlast_err_r;

endmodule
